gups_addr_gen: RTL
==================

Name: gups_addr_gen

Overview:
- Upstream address source for the GUPS update engine (`sys`). It produces the stream of pseudo-random update addresses that `sys` read-modify-writes (+1).
- Four 16-bit Galois LFSR lanes are concatenated into a 64-bit word and masked by `range`.
- Addresses go out over a valid/ready handshake backed by a 2-entry skid buffer.
- The block issues exactly `num_updates` addresses per run, then signals done.

Parameters:
- LFSR_TAPS, 16'hB400, Galois tap mask (x^16+x^14+x^13+x^11+1), shared by all lanes.
- ZERO_SEED_SUB, 16'hACE1, value loaded into any lane whose seed is 0 (0 would lock the LFSR).
- CNT_W, 32, width of `num_updates` and `issued`.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run. Honoured only in IDLE or DONE.
- seed0  in  16  lane 0 seed; forms addr bits [15:0].
- seed1  in  16  lane 1 seed; forms addr bits [31:16].
- seed2  in  16  lane 2 seed; forms addr bits [47:32].
- seed3  in  16  lane 3 seed; forms addr bits [63:48].
- range  in  64  address mask, 2^k-1 form (e.g. 64'h1fff).
- num_updates  in  CNT_W  number of addresses to issue in the run.
- addr_out  out  64  update address; stable while addr_valid=1 and addr_ready=0.
- addr_valid  out  1  addr_out holds a valid address.
- addr_ready  in  1  consumer accepts; a transfer occurs when valid and ready are both 1 at a clk edge.
- issued  out  CNT_W  count of addresses accepted by the consumer in this run.
- busy  out  1  run in progress (RUN state).
- done  out  1  run complete; held high until the next start or rst.

Behaviour:
- Reset, sampled at clk edge while rst=1:
  - state=IDLE; LFSR lanes, latched range and counters cleared; skid buffer flushed.
  - Outputs: addr_out=0, addr_valid=0, issued=0, busy=0, done=0.
  - rst overrides start. rst mid-run aborts immediately; any unaccepted addresses are lost.
- States: IDLE, RUN, DONE.
- IDLE/DONE, start=1:
  - Latch seeds into lanes, substituting ZERO_SEED_SUB for any seed equal to 0.
  - Latch range and num_updates; clear the gen and issued counters; clear done.
  - If num_updates=0, go to DONE (done=1 the next cycle). Otherwise go to RUN and set busy=1.
- RUN, generation:
  - Each cycle with gen<num_updates and buffer not full, push the candidate {l3,l2,l1,l0} & range_q into the buffer.
  - On each push, step all four lanes: l = l[0] ? (l>>1)^LFSR_TAPS : (l>>1). Increment gen.
  - The first pushed address uses the latched seeds unstepped.
- Timing:
  - addr_valid first rises 2 cycles after the start edge.
  - With addr_ready held at 1, the block sustains one address per cycle with no bubbles.
- Handshake and backpressure:
  - Standard valid/ready. Once addr_valid=1 it stays 1 and addr_out stays stable until accepted.
  - addr_ready may toggle arbitrarily. The LFSRs never step without a push, so the sequence is independent of backpressure.
- Counting: `issued` increments on each accepted transfer.
- RUN -> DONE when gen=num_updates and the buffer is empty (issued=num_updates).
  - busy=0 and done=1 in the same cycle; addr_valid=0 from then on.
- start asserted during RUN is ignored.
- range is not checked for mask form. A non-mask value is simply ANDed, which is defined behaviour. The caller is responsible for passing a mask.
- Width rules: gen and issued are CNT_W bits wide and never exceed num_updates, so no wrap.
- Simultaneous start and accept in DONE cannot occur, because addr_valid=0 there.

Decomposition:
- Package gups_pkg:
  - LFSR_TAPS and ZERO_SEED_SUB constants.
  - State encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Function lfsr16_step().
- Sub-module gups_skid_buf:
  - 2-entry, 64-bit, registered valid/ready buffer.
  - Ports: clk, rst, in_data, in_valid, in_ready, out_data, out_valid, out_ready.
  - Full/empty are internal.
- The top level holds the FSM, the four lanes and the counters.

Test Plan:
- Reset: hold rst 3 cycles, mid-idle and mid-run -> all outputs 0, state IDLE, next start behaves as a fresh run.
- Sequence check: seeds 1,2,3,4, range 64'h1fff, num_updates=2, ready=1 -> addr_out 64'h0001 then 64'h1400; issued=2; done=1; no third valid.
- Zero seeds: all seeds 0, range all-ones, num_updates=1 -> addr_out 64'hACE1ACE1ACE1ACE1.
- Backpressure: seeds 1,2,3,4, num_updates=64, random addr_ready -> accepted sequence matches a golden LFSR model; addr_out stable while stalled; issued=64 at done.
- Zero count: num_updates=0, start -> busy never 1, addr_valid never 1, done=1 the cycle after start.
- Range and ignored start: range 64'hff over 1000 updates -> every addr <= 64'hff. A start pulse mid-run is ignored and issued still ends at 1000.

Source files
------------

// File: rtl/gups_pkg.sv
// Shared constants, FSM encoding and LFSR step function for the GUPS address generator.
package gups_pkg;

    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] ZERO_SEED_SUB = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gups_state_e;

    // One Galois step: shift right and fold the taps in when a 1 falls out.
    function automatic logic [15:0] lfsr16_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ LFSR_TAPS) : (l >> 1);
    endfunction

    // An all-zero lane would never leave zero, so swap in a fixed nonzero seed.
    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'h0) ? ZERO_SEED_SUB : s;
    endfunction

endpackage

// File: rtl/gups_skid_buf.sv
// Two-entry registered valid/ready buffer carrying 64-bit update addresses.
module gups_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    logic [63:0] r_mem [2];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;

    logic        w_push;
    logic        w_pop;

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_mem[r_rptr];

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= in_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/gups_addr_gen.sv
// GUPS update-address source: four 16-bit LFSR lanes, masked by range, issued over
// valid/ready through a skid buffer, exactly num_updates per run.
module gups_addr_gen
    import gups_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      seed0,
    input  logic [15:0]      seed1,
    input  logic [15:0]      seed2,
    input  logic [15:0]      seed3,
    input  logic [63:0]      range,
    input  logic [CNT_W-1:0] num_updates,
    output logic [63:0]      addr_out,
    output logic             addr_valid,
    input  logic             addr_ready,
    output logic [CNT_W-1:0] issued,
    output logic             busy,
    output logic             done
);

    gups_state_e      r_state;
    logic [15:0]      r_lane [4];
    logic [63:0]      r_range;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_gen;
    logic [CNT_W-1:0] r_issued;
    logic             r_busy;
    logic             r_done;

    logic [63:0]      w_cand;
    logic             w_buf_in_ready;
    logic             w_buf_valid;
    logic             w_push;
    logic             w_accept;
    logic [CNT_W-1:0] w_issued_nxt;

    assign w_cand       = {r_lane[3], r_lane[2], r_lane[1], r_lane[0]} & r_range;
    assign w_push       = (r_state == RUN) && (r_gen < r_num) && w_buf_in_ready;
    assign w_accept     = w_buf_valid && addr_ready;
    assign w_issued_nxt = r_issued + {{(CNT_W-1){1'b0}}, w_accept};

    gups_skid_buf u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .in_data   (w_cand),
        .in_valid  (w_push),
        .in_ready  (w_buf_in_ready),
        .out_data  (addr_out),
        .out_valid (w_buf_valid),
        .out_ready (addr_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            for (int i = 0; i < 4; i++) begin
                r_lane[i] <= 16'h0;
            end
            r_range  <= '0;
            r_num    <= '0;
            r_gen    <= '0;
            r_issued <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_lane[0] <= seed_fix(seed0);
                        r_lane[1] <= seed_fix(seed1);
                        r_lane[2] <= seed_fix(seed2);
                        r_lane[3] <= seed_fix(seed3);
                        r_range   <= range;
                        r_num     <= num_updates;
                        r_gen     <= '0;
                        r_issued  <= '0;
                        if (num_updates == '0) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    // Lanes advance only on a push, so backpressure never perturbs the sequence.
                    if (w_push) begin
                        for (int i = 0; i < 4; i++) begin
                            r_lane[i] <= lfsr16_step(r_lane[i]);
                        end
                        r_gen <= r_gen + 1'b1;
                    end
                    r_issued <= w_issued_nxt;
                    // issued reaching num implies every address was generated and drained.
                    if (w_issued_nxt == r_num) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign addr_valid = w_buf_valid;
    assign issued     = r_issued;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
